int_to_floating_point_conversion: RTL and testbench

Multi-cycle converter from a 32-bit integer (signed two's-complement or unsigned) to an IEEE-754 single-precision value, rounded to nearest-even. It is the producer-side counterpart of the floating-point adder: it generates the packed sign/exponent/mantissa words that the adder consumes. Normalization is iterative, a one-bit left shift per cycle. Input and output use valid/ready handshakes.

---
 rtl/int_to_floating_point_conversion.sv | 103 ++++++++++
 tb/tb_int_to_floating_point_conversion.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_floating_point_conversion.sv
// Integer (signed or unsigned) to IEEE-754 single-precision converter.
// Normalizes with a one-bit left shift per cycle and rounds to nearest-even.
// Valid/ready handshakes on both the operand and the result side.
module int_to_floating_point_conversion #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MENT_WIDTH = 23,
   parameter int unsigned EXPO_WIDTH = 8,
   parameter int unsigned EXPO_BIAS  = 127
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [DATA_WIDTH-1:0] integer_in,
   input  logic                  signed_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   output logic [DATA_WIDTH-1:0] floating_out,
   output logic                  inexact_out,
   output logic                  valid_out,
   input  logic                  ready_in
);

   // Bit just below the kept mantissa field once mag is normalized.
   localparam int unsigned GRD_BIT = DATA_WIDTH - 2 - MENT_WIDTH;
   // Exponent of an operand whose top bit is already set.
   localparam logic [EXPO_WIDTH-1:0] EXP_INIT = EXPO_WIDTH'(EXPO_BIAS + DATA_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StNorm, StDone} state_t;

   state_t                  state_q;
   logic [DATA_WIDTH-1:0]   mag_q;
   logic [EXPO_WIDTH-1:0]   exp_q;
   logic                    sign_q;

   logic                    sign_in;
   logic [DATA_WIDTH-1:0]   mag_in;
   logic [MENT_WIDTH-1:0]   mant_trunc;
   logic                    guard;
   logic                    sticky;
   logic                    round_up;
   logic [MENT_WIDTH:0]     mant_sum;
   logic [EXPO_WIDTH-1:0]   exp_rnd;

   // Handshake flags decoded from the state register.
   assign ready_out = (state_q == StIdle);
   assign valid_out = (state_q == StDone);

   // Operand sign/magnitude and round-to-nearest-even of the normalized magnitude.
   always_comb begin
      sign_in    = signed_in & integer_in[DATA_WIDTH-1];
      mag_in     = sign_in ? (~integer_in + DATA_WIDTH'(1)) : integer_in;
      mant_trunc = mag_q[DATA_WIDTH-2 -: MENT_WIDTH];
      guard      = mag_q[GRD_BIT];
      sticky     = |mag_q[GRD_BIT-1:0];
      round_up   = guard & (sticky | mant_trunc[0]);
      mant_sum   = {1'b0, mant_trunc} + {{MENT_WIDTH{1'b0}}, round_up};
      // A carry out of the mantissa leaves it all zero and bumps the exponent.
      exp_rnd    = exp_q + {{(EXPO_WIDTH-1){1'b0}}, mant_sum[MENT_WIDTH]};
   end

   // Control FSM with datapath registers and registered result.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= StIdle;
         mag_q        <= '0;
         exp_q        <= '0;
         sign_q       <= 1'b0;
         floating_out <= '0;
         inexact_out  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (valid_in) begin
                  sign_q <= sign_in;
                  mag_q  <= mag_in;
                  if (mag_in == '0) begin
                     floating_out <= '0;
                     inexact_out  <= 1'b0;
                     state_q      <= StDone;
                  end else begin
                     exp_q   <= EXP_INIT;
                     state_q <= StNorm;
                  end
               end
            end
            StNorm: begin
               if (!mag_q[DATA_WIDTH-1]) begin
                  mag_q <= mag_q << 1;
                  exp_q <= exp_q - {{(EXPO_WIDTH-1){1'b0}}, 1'b1};
               end else begin
                  floating_out <= {sign_q, exp_rnd, mant_sum[MENT_WIDTH-1:0]};
                  inexact_out  <= guard | sticky;
                  state_q      <= StDone;
               end
            end
            StDone: begin
               if (ready_in) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_int_to_floating_point_conversion.sv
// Directed and model-checked bench for the int-to-float converter.
module tb_int_to_floating_point_conversion;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic [31:0] integer_in = '0;
   logic        signed_in = 1'b0;
   logic        valid_in = 1'b0;
   logic        ready_out;
   logic [31:0] floating_out;
   logic        inexact_out;
   logic        valid_out;
   logic        ready_in = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   int_to_floating_point_conversion dut (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .integer_in   (integer_in),
      .signed_in    (signed_in),
      .valid_in     (valid_in),
      .ready_out    (ready_out),
      .floating_out (floating_out),
      .inexact_out  (inexact_out),
      .valid_out    (valid_out),
      .ready_in     (ready_in)
   );

   // Present an operand and hold it until the accepting edge.
   task automatic start_conv(input logic [31:0] v, input logic s);
      int n;
      @(negedge clk_in);
      integer_in = v;
      signed_in  = s;
      valid_in   = 1'b1;
      n = 0;
      while (!ready_out && n < 100) begin
         @(negedge clk_in);
         n++;
      end
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
   endtask

   // Count edges until valid_out, bounded; lat 40 means it never came.
   task automatic wait_result(output logic [31:0] f, output logic inx, output int lat);
      lat = 0;
      while (!valid_out && lat < 40) begin
         @(posedge clk_in);
         #1;
         lat++;
      end
      f   = floating_out;
      inx = inexact_out;
   endtask

   task automatic handshake();
      @(negedge clk_in);
      ready_in = 1'b1;
      @(posedge clk_in);
      #1;
      ready_in = 1'b0;
   endtask

   // Independent reference: locate msb, round the dropped bits to nearest-even.
   task automatic ref_conv(input logic [31:0] v, input logic s,
                           output logic [31:0] f, output logic inx, output int lat);
      logic        sg;
      logic [63:0] mag, kept, rem, half;
      int          p, e, sh;
      sg  = s & v[31];
      mag = {32'd0, sg ? (32'd0 - v) : v};
      if (mag == 0) begin
         f = '0; inx = 1'b0; lat = 0;
      end else begin
         p = 0;
         for (int i = 0; i < 32; i++) if (mag[i]) p = i;
         lat = 32 - p;
         e   = 127 + p;
         if (p <= 23) begin
            kept = mag << (23 - p);
            inx  = 1'b0;
         end else begin
            sh   = p - 23;
            kept = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && kept[0])) kept = kept + 1;
            if (kept[24]) begin
               kept = kept >> 1;
               e++;
            end
         end
         f = {sg, 8'(e), kept[22:0]};
      end
   endtask

   task automatic test_reset();
      checks++;
      if (ready_out !== 1'b1 || valid_out !== 1'b0 || floating_out !== 32'h0
          || inexact_out !== 1'b0) begin
         errors++;
         $display("FAIL reset: rdy=%b vld=%b f=%h inx=%b, want rdy=1 vld=0 f=0 inx=0",
                  ready_out, valid_out, floating_out, inexact_out);
      end
   endtask

   task automatic test_one_minus_one();
      logic [31:0] f; logic inx; int lat;
      start_conv(32'h0000_0001, 1'b1);
      wait_result(f, inx, lat);
      checks++;
      if (lat !== 32) begin
         errors++; $display("FAIL one_latency: got %0d want 32", lat);
      end
      checks++;
      if (f !== 32'h3F80_0000 || inx !== 1'b0) begin
         errors++; $display("FAIL one_value: got %h/%b want 3f800000/0", f, inx);
      end
      handshake();
      checks++;
      if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
         errors++;
         $display("FAIL one_handshake: vld=%b rdy=%b want vld=0 rdy=1", valid_out, ready_out);
      end
      start_conv(32'hFFFF_FFFF, 1'b1);
      wait_result(f, inx, lat);
      checks++;
      if (f !== 32'hBF80_0000 || inx !== 1'b0 || lat !== 32) begin
         errors++;
         $display("FAIL minus_one: got %h/%b lat %0d want bf800000/0 lat 32", f, inx, lat);
      end
      handshake();
   endtask

   task automatic test_zero_and_min();
      logic [31:0] f; logic inx; int lat;
      start_conv(32'h0000_0000, 1'b1);
      wait_result(f, inx, lat);
      checks++;
      if (f !== 32'h0 || inx !== 1'b0 || lat !== 0) begin
         errors++; $display("FAIL zero: got %h/%b lat %0d want 0/0 lat 0", f, inx, lat);
      end
      handshake();
      start_conv(32'h8000_0000, 1'b1);
      wait_result(f, inx, lat);
      checks++;
      if (f !== 32'hCF00_0000 || inx !== 1'b0 || lat !== 1) begin
         errors++;
         $display("FAIL signed_min: got %h/%b lat %0d want cf000000/0 lat 1", f, inx, lat);
      end
      handshake();
      start_conv(32'h8000_0000, 1'b0);
      wait_result(f, inx, lat);
      checks++;
      if (f !== 32'h4F00_0000 || inx !== 1'b0 || lat !== 1) begin
         errors++;
         $display("FAIL unsigned_top: got %h/%b lat %0d want 4f000000/0 lat 1", f, inx, lat);
      end
      handshake();
   endtask

   task automatic test_rounding();
      logic [31:0] vin  [4] = '{32'h0100_0001, 32'h0100_0003, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
      logic        sin  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [31:0] want [4] = '{32'h4B80_0000, 32'h4B80_0002, 32'h4F00_0000, 32'h4F80_0000};
      logic [31:0] f; logic inx; int lat;
      for (int i = 0; i < 4; i++) begin
         start_conv(vin[i], sin[i]);
         wait_result(f, inx, lat);
         checks++;
         if (f !== want[i] || inx !== 1'b1) begin
            errors++;
            $display("FAIL rounding[%0d]: got %h/%b want %h/1", i, f, inx, want[i]);
         end
         handshake();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] f; logic inx; int lat; int bad;
      start_conv(32'h0000_0005, 1'b0);
      wait_result(f, inx, lat);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_in);
         #1;
         if (valid_out !== 1'b1 || floating_out !== 32'h40A0_0000 || inexact_out !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL backpressure: %0d unstable cycles, last %b/%h/%b want 1/40a00000/0",
                  bad, valid_out, floating_out, inexact_out);
      end
      handshake();
   endtask

   task automatic test_ignore_busy();
      logic [31:0] f; logic inx; int lat; int bad;
      start_conv(32'h0000_0001, 1'b0);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_in);
         integer_in = 32'h1234_5678 + 32'(i);
         signed_in  = i[0];
         valid_in   = 1'b1;
         @(posedge clk_in);
         #1;
         if (ready_out !== 1'b0) bad++;
      end
      valid_in = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL busy_ready: ready_out high in %0d busy cycles, want 0", bad);
      end
      wait_result(f, inx, lat);
      checks++;
      if (f !== 32'h3F80_0000 || inx !== 1'b0 || lat + 5 !== 32) begin
         errors++;
         $display("FAIL busy_result: got %h/%b lat %0d want 3f800000/0 lat 32", f, inx, lat + 5);
      end
      handshake();
   endtask

   task automatic test_reset_mid_norm();
      logic [31:0] f; logic inx; int lat; int seen;
      start_conv(32'h0000_0001, 1'b1);
      repeat (9) @(posedge clk_in);
      #2;
      rst_n_in = 1'b0;
      #1;
      checks++;
      if (ready_out !== 1'b1 || valid_out !== 1'b0 || floating_out !== 32'h0
          || inexact_out !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: rdy=%b vld=%b f=%h inx=%b want 1/0/0/0",
                  ready_out, valid_out, floating_out, inexact_out);
      end
      @(negedge clk_in);
      rst_n_in = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_in);
         #1;
         if (valid_out) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL mid_reset_drop: valid_out seen %0d cycles want 0", seen);
      end
      start_conv(32'h0000_0003, 1'b1);
      wait_result(f, inx, lat);
      checks++;
      if (f !== 32'h4040_0000 || inx !== 1'b0 || lat !== 31) begin
         errors++;
         $display("FAIL after_reset: got %h/%b lat %0d want 40400000/0 lat 31", f, inx, lat);
      end
      handshake();
   endtask

   task automatic test_random();
      logic [31:0] v, f, wf; logic s, inx, winx; int lat, wlat, d;
      for (int n = 0; n < 300; n++) begin
         v = $urandom() >> $urandom_range(0, 31);
         if ($urandom_range(0, 3) == 0) v = ~v;
         s = 1'($urandom_range(0, 1));
         ref_conv(v, s, wf, winx, wlat);
         repeat ($urandom_range(0, 2)) @(negedge clk_in);
         start_conv(v, s);
         wait_result(f, inx, lat);
         checks++;
         if (f !== wf || inx !== winx || lat !== wlat) begin
            errors++;
            $display("FAIL random %h s=%b: got %h/%b lat %0d want %h/%b lat %0d",
                     v, s, f, inx, lat, wf, winx, wlat);
         end
         d = $urandom_range(0, 3);
         repeat (d) @(posedge clk_in);
         #1;
         handshake();
         checks++;
         if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL random_handshake %0d: vld=%b rdy=%b want 0/1", n, valid_out, ready_out);
         end
      end
   endtask

   initial begin
      #12;
      test_reset();
      @(negedge clk_in);
      rst_n_in = 1'b1;
      test_one_minus_one();
      test_zero_and_min();
      test_rounding();
      test_backpressure();
      test_ignore_busy();
      test_reset_mid_norm();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
